// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared funct3 codes, FSM state type and funct3 legality helper for the data-memory responder
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        DM_IDLE,
        DM_WAIT,
        DM_RESP
    } dmem_state_t;

    function automatic logic is_legal_f3(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering, load extension, store byte enables and misalignment detect
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata,
    output logic        misaligned
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = 8'h00;
        case (offset)
            2'd0: lane_byte = rdata[7:0];
            2'd1: lane_byte = rdata[15:8];
            2'd2: lane_byte = rdata[23:16];
            2'd3: lane_byte = rdata[31:24];
            default: lane_byte = 8'h00;
        endcase
        lane_half = offset[1] ? rdata[31:16] : rdata[15:0];

        load_data = 32'h0;
        case (funct3)
            F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
            F3_BU:   load_data = {24'h0, lane_byte};
            F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
            F3_HU:   load_data = {16'h0, lane_half};
            F3_W:    load_data = rdata;
            default: load_data = 32'h0;
        endcase

        // Store width comes from funct3[1:0]; the unsigned bit has no meaning for stores.
        byte_en = 4'b0000;
        wdata   = store_data;
        case (funct3[1:0])
            2'b00: begin
                byte_en = 4'b0001 << offset;
                wdata   = {4{store_data[7:0]}};
            end
            2'b01: begin
                byte_en = offset[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{store_data[15:0]}};
            end
            2'b10: begin
                byte_en = 4'b1111;
                wdata   = store_data;
            end
            default: begin
                byte_en = 4'b0000;
                wdata   = store_data;
            end
        endcase

        misaligned = ((funct3[1:0] == 2'b01) && offset[0])
                  || ((funct3[1:0] == 2'b10) && (offset != 2'b00));
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory port responder: request latch, wait-state FSM and byte-enabled SRAM
module dmem_responder
    import dmem_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE   = 32'h8000_2000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_m_addr,
    input  logic [31:0] data_m_in,
    input  logic        data_m_R,
    input  logic        data_m_W,
    input  logic [2:0]  data_m_instr,
    output logic [31:0] data_m_out,
    output logic        data_m_ready,
    output logic        data_m_err
);

    localparam int          CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(4 * DEPTH_WORDS);

    dmem_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      a_addr;
    logic [31:0]      a_wdata;
    logic [2:0]       a_f3;
    logic             a_r;
    logic             a_w;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] offset;
    logic        in_range;
    logic [AW-1:0] word_idx;
    logic [31:0] rdata;
    logic [31:0] load_data;
    logic [3:0]  byte_en;
    logic [31:0] wdata;
    logic        misaligned;
    logic        acc_err;
    logic        do_access;

    // Unsigned subtraction makes addresses below the base wrap far out of range.
    assign offset    = a_addr - DMEM_BASE;
    assign in_range  = {1'b0, offset} < SPAN;
    assign word_idx  = offset[AW+1:2];
    assign rdata     = mem[word_idx];
    assign acc_err   = (a_r && a_w) || !is_legal_f3(a_f3) || misaligned || !in_range;
    assign do_access = (state == DM_WAIT) && (cnt == '0);

    dmem_lane_align u_align (
        .funct3     (a_f3),
        .offset     (offset[1:0]),
        .rdata      (rdata),
        .store_data (a_wdata),
        .load_data  (load_data),
        .byte_en    (byte_en),
        .wdata      (wdata),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= DM_IDLE;
            cnt        <= '0;
            a_addr     <= 32'h0;
            a_wdata    <= 32'h0;
            a_f3       <= 3'b000;
            a_r        <= 1'b0;
            a_w        <= 1'b0;
            data_m_out <= 32'h0;
            data_m_err <= 1'b0;
        end else begin
            case (state)
                DM_IDLE: begin
                    if (data_m_R || data_m_W) begin
                        a_addr  <= data_m_addr;
                        a_wdata <= data_m_in;
                        a_f3    <= data_m_instr;
                        a_r     <= data_m_R;
                        a_w     <= data_m_W;
                        cnt     <= CNT_W'(WAIT_CYCLES);
                        state   <= DM_WAIT;
                    end
                end
                DM_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        data_m_out <= (a_r && !acc_err) ? load_data : 32'h0;
                        data_m_err <= acc_err;
                        state      <= DM_RESP;
                    end
                end
                DM_RESP: state <= DM_IDLE;
                default: state <= DM_IDLE;
            endcase
        end
    end

    // No reset on the array: contents survive reset, and reset forces IDLE so no write slips through.
    always_ff @(posedge clk) begin
        if (do_access && a_w && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign data_m_ready = (state == DM_RESP);

endmodule
